// File: rtl/sevenseg_scan.sv
// Purpose : time-multiplexed 7-segment digit scanner (nibble + active-low anode per slot)
// Latency : outputs registered, 1 cycle after any scan/snapshot state change
// Backpressure: none; free-running scan, load accepted on any cycle
module sevenseg_scan #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] value,
  input  logic [7:0]  digit_en,
  output logic [3:0]  data,
  output logic [7:0]  anodes,
  output logic        frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [31:0]      val_q;
  logic [7:0]       en_q;

  logic       tick;
  logic       wrap;
  logic       in_blank;
  logic       lit;
  logic [3:0] nib;
  logic [7:0] sel;

  // A slot ends on the last divider count; a frame ends when the last digit's slot ends.
  assign tick = (cnt == CNT_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  // The blanking window is empty when BLANK_CYCLES is 0, so no comparison is built then.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt < CNT_W'(BLANK_CYCLES));
    end
  endgenerate

  // Select the current digit's nibble, enable bit and one-hot anode from the snapshot.
  always_comb begin
    nib = 4'h0;
    lit = 1'b0;
    sel = 8'hFF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib    = val_q[4*i +: 4];
        lit    = en_q[i];
        sel[i] = 1'b0;
      end
    end
  end

  // Slot divider and digit index; the index only moves on the slot tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Snapshot of value/enable, independent of the scan position.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
      en_q  <= '0;
    end else if (load) begin
      val_q <= value;
      en_q  <= digit_en;
    end
  end

  // Registered outputs: anodes stay off during blanking or for a masked digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      data       <= 4'h0;
      anodes     <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      data       <= nib;
      anodes     <= (in_blank || !lit) ? 8'hFF : sel;
      frame_done <= wrap;
    end
  end

endmodule
